// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, write-back forwarding and a stall counter.
// Optional macro ID_EX_WB_BYPASS_EN: forward the committing write-back value; otherwise stall on that hazard.

`ifndef GPR_RD
`define GPR_RD 2'b01
`endif
`ifndef GPR_RT
`define GPR_RT 2'b10
`endif
`ifndef GPR_RA
`define GPR_RA 2'b11
`endif

module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [31:0]       id_pc,
  input  logic [DATA_W-1:0] id_reg_rs,
  input  logic [DATA_W-1:0] id_reg_rt,
  input  logic [1:0]        id_gpr_w_sel,
  input  logic              id_mem_read,
  input  logic              wb_we,
  input  logic [4:0]        wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [31:0]       ex_instr,
  output logic [31:0]       ex_pc,
  output logic [DATA_W-1:0] ex_rs_val,
  output logic [DATA_W-1:0] ex_rt_val,
  output logic [4:0]        ex_dst,
  output logic [1:0]        ex_gpr_w_sel,
  output logic              ex_mem_read,
  output logic [15:0]       stall_cnt
);

  function automatic logic [4:0] dst_decode(input logic [1:0] sel, input logic [31:0] instr);
    logic [4:0] d;
    d = 5'd0;
    case (sel)
      `GPR_RD: d = instr[15:11];
      `GPR_RT: d = instr[20:16];
      `GPR_RA: d = 5'd31;
      default: d = 5'd0;
    endcase
    return d;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [DATA_W-1:0] wb_fwd(input logic [4:0] src, input logic [DATA_W-1:0] rf_val,
                                               input logic we, input logic [4:0] dst,
                                               input logic [DATA_W-1:0] data);
    return (we && dst != 5'd0 && dst == src) ? data : rf_val;
  endfunction

  // ---- ID stage (p0): operand selection and hazard detection
  logic [4:0]        rs_p0;
  logic [4:0]        rt_p0;
  logic              load_use_p0;
  logic              wb_haz_p0;
  logic [DATA_W-1:0] rs_val_p0;
  logic [DATA_W-1:0] rt_val_p0;

  logic              vld_p1;
  logic [31:0]       instr_p1;
  logic [31:0]       pc_p1;
  logic [DATA_W-1:0] rs_val_p1;
  logic [DATA_W-1:0] rt_val_p1;
  logic [4:0]        dst_p1;
  logic [1:0]        w_sel_p1;
  logic              mem_rd_p1;
  logic [15:0]       cnt_p1;

  assign rs_p0 = id_instr[25:21];
  assign rt_p0 = id_instr[20:16];

  assign load_use_p0 = id_valid && vld_p1 && mem_rd_p1 && (dst_p1 != 5'd0) &&
                       ((dst_p1 == rs_p0) || (dst_p1 == rt_p0));

`ifdef ID_EX_WB_BYPASS_EN
  assign wb_haz_p0 = 1'b0;
  assign rs_val_p0 = wb_fwd(rs_p0, id_reg_rs, wb_we, wb_dst, wb_data);
  assign rt_val_p0 = wb_fwd(rt_p0, id_reg_rt, wb_we, wb_dst, wb_data);
`else
  // Without forwarding the register file read is stale for one cycle; hold ID and re-read.
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign wb_haz_p0 = id_valid && wb_we && (wb_dst != 5'd0) &&
                     ((wb_dst == rs_p0) || (wb_dst == rt_p0));
  assign rs_val_p0 = id_reg_rs;
  assign rt_val_p0 = id_reg_rt;
`endif

  assign stall = (load_use_p0 || wb_haz_p0) && !flush;

  // ---- EX stage (p1): pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      instr_p1  <= '0;
      pc_p1     <= '0;
      rs_val_p1 <= '0;
      rt_val_p1 <= '0;
      dst_p1    <= '0;
      w_sel_p1  <= '0;
      mem_rd_p1 <= 1'b0;
      cnt_p1    <= '0;
    end else begin
      instr_p1  <= id_instr;
      pc_p1     <= id_pc;
      rs_val_p1 <= rs_val_p0;
      rt_val_p1 <= rt_val_p0;
      if (flush || stall) begin
        vld_p1    <= 1'b0;
        dst_p1    <= 5'd0;
        w_sel_p1  <= 2'd0;
        mem_rd_p1 <= 1'b0;
      end else begin
        vld_p1    <= id_valid;
        dst_p1    <= dst_decode(id_gpr_w_sel, id_instr);
        w_sel_p1  <= id_gpr_w_sel;
        mem_rd_p1 <= id_mem_read;
      end
      if (stall) begin
        cnt_p1 <= sat_inc(cnt_p1);
      end
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_instr     = instr_p1;
  assign ex_pc        = pc_p1;
  assign ex_rs_val    = rs_val_p1;
  assign ex_rt_val    = rt_val_p1;
  assign ex_dst       = dst_p1;
  assign ex_gpr_w_sel = w_sel_p1;
  assign ex_mem_read  = mem_rd_p1;
  assign stall_cnt    = cnt_p1;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against a behavioural model.
`timescale 1ns/1ps
module tb_id_ex_stage;
  localparam logic [1:0] SEL_NONE = 2'b00, SEL_RD = 2'b01, SEL_RT = 2'b10, SEL_RA = 2'b11;
  localparam int K_RESET = 0, K_FLUSH = 1, K_STALL = 2, K_LOAD = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_reg_rs, id_reg_rt;
  logic [1:0]  id_gpr_w_sel;
  logic        id_mem_read;
  logic        wb_we;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        flush;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_instr, ex_pc, ex_rs_val, ex_rt_val;
  logic [4:0]  ex_dst;
  logic [1:0]  ex_gpr_w_sel;
  logic        ex_mem_read;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;
  int exp_cnt;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_reg_rs(id_reg_rs), .id_reg_rt(id_reg_rt), .id_gpr_w_sel(id_gpr_w_sel),
    .id_mem_read(id_mem_read), .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data),
    .flush(flush), .stall(stall), .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc),
    .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_dst(ex_dst),
    .ex_gpr_w_sel(ex_gpr_w_sel), .ex_mem_read(ex_mem_read), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = '0, m_pc = '0, m_rs = '0, m_rt = '0;
  logic [4:0]  m_dst = '0;
  logic [1:0]  m_sel = '0;
  logic        m_mrd = 1'b0;
  int          m_cnt = 0;
  int          m_kind = K_RESET;

  function automatic logic [4:0] model_dst(input logic [1:0] sel, input logic [31:0] ins);
    if (sel == SEL_RD) return ins[15:11];
    if (sel == SEL_RT) return ins[20:16];
    if (sel == SEL_RA) return 5'd31;
    return 5'd0;
  endfunction

  function automatic logic model_stall();
    logic [4:0] rs, rt;
    logic lu, wbh;
    rs  = id_instr[25:21];
    rt  = id_instr[20:16];
    lu  = id_valid && m_valid && m_mrd && m_dst != 0 && (m_dst == rs || m_dst == rt);
    wbh = 1'b0;
`ifndef ID_EX_WB_BYPASS_EN
    wbh = id_valid && wb_we && wb_dst != 0 && (wb_dst == rs || wb_dst == rt);
`endif
    return (lu || wbh) && !flush;
  endfunction

  function automatic logic [31:0] model_val(input logic [4:0] r, input logic [31:0] rf);
`ifdef ID_EX_WB_BYPASS_EN
    if (wb_we && wb_dst != 0 && wb_dst == r) return wb_data;
`endif
    return rf;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_instr <= '0; m_pc <= '0; m_rs <= '0; m_rt <= '0;
      m_dst <= '0; m_sel <= '0; m_mrd <= 1'b0; m_cnt <= 0; m_kind <= K_RESET;
    end else if (flush) begin
      m_valid <= 1'b0; m_sel <= 2'd0; m_mrd <= 1'b0; m_kind <= K_FLUSH;
    end else if (model_stall()) begin
      m_valid <= 1'b0; m_mrd <= 1'b0; m_dst <= 5'd0; m_kind <= K_STALL;
      m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else begin
      m_valid <= id_valid; m_instr <= id_instr; m_pc <= id_pc;
      m_rs <= model_val(id_instr[25:21], id_reg_rs);
      m_rt <= model_val(id_instr[20:16], id_reg_rt);
      m_dst <= model_dst(id_gpr_w_sel, id_instr);
      m_sel <= id_gpr_w_sel; m_mrd <= id_mem_read; m_kind <= K_LOAD;
    end
  end

  // Compare on the inactive edge every cycle once checking is enabled.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", {31'd0, stall}, {31'd0, model_stall()});
      chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
      chk("stall_cnt", {16'd0, stall_cnt}, m_cnt);
      if (m_valid) begin
        chk("ex_instr", ex_instr, m_instr);
        chk("ex_pc", ex_pc, m_pc);
        chk("ex_rs_val", ex_rs_val, m_rs);
        chk("ex_rt_val", ex_rt_val, m_rt);
        chk("ex_dst", {27'd0, ex_dst}, {27'd0, m_dst});
        chk("ex_gpr_w_sel", {30'd0, ex_gpr_w_sel}, {30'd0, m_sel});
        chk("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m_mrd});
      end else if (m_kind == K_FLUSH) begin
        chk("flush_w_sel", {30'd0, ex_gpr_w_sel}, 32'd0);
        chk("flush_mem_read", {31'd0, ex_mem_read}, 32'd0);
      end else if (m_kind == K_STALL) begin
        chk("bubble_dst", {27'd0, ex_dst}, 32'd0);
        chk("bubble_mem_read", {31'd0, ex_mem_read}, 32'd0);
      end else if (m_kind == K_RESET) begin
        chk("rst_instr", ex_instr, 32'd0);
        chk("rst_pc", ex_pc, 32'd0);
        chk("rst_rs", ex_rs_val, 32'd0);
        chk("rst_rt", ex_rt_val, 32'd0);
        chk("rst_ctl", {24'd0, ex_dst, ex_gpr_w_sel, ex_mem_read}, 32'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'h00, rs, rt, rd, 11'h000};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_id(input logic [31:0] ins, input logic [1:0] sel, input logic mrd);
    id_valid = 1'b1; id_instr = ins; id_gpr_w_sel = sel; id_mem_read = mrd;
  endtask

  task automatic rand_inputs();
    id_valid     = ($urandom_range(0, 9) < 8);
    id_instr     = {6'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 11'($urandom)};
    id_pc        = $urandom;
    id_reg_rs    = $urandom;
    id_reg_rt    = $urandom;
    id_gpr_w_sel = 2'($urandom);
    id_mem_read  = 1'($urandom);
    wb_we        = 1'($urandom);
    wb_dst       = 5'($urandom_range(0, 3));
    wb_data      = $urandom;
    flush        = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 0; id_instr = 0; id_pc = 0; id_reg_rs = 0; id_reg_rt = 0;
    id_gpr_w_sel = 0; id_mem_read = 0; wb_we = 0; wb_dst = 0; wb_data = 0; flush = 0;
    repeat (2) step();
    chk_en = 1'b1;
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_pc", ex_pc, 32'd0);
    chk("reset_cnt", {16'd0, stall_cnt}, 32'd0);

    // First instruction after reset release
    rst_n = 1'b1;
    set_id(mk(5'd1, 5'd2, 5'd3), SEL_RD, 1'b0);
    id_pc = 32'h3000; id_reg_rs = 32'h11; id_reg_rt = 32'h22;
    step();
    chk("first_valid", {31'd0, ex_valid}, 32'd1);
    chk("first_pc", ex_pc, 32'h3000);
    chk("first_rs", ex_rs_val, 32'h11);
    chk("first_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("first_dst", {27'd0, ex_dst}, 32'd3);
    exp_cnt = 0;

    // Load-use: lw writing r8 followed by a reader of r8
    set_id(mk(5'd1, 5'd8, 5'd0), SEL_RT, 1'b1);
    step();
    chk("lw_dst", {27'd0, ex_dst}, 32'd8);
    set_id(mk(5'd8, 5'd2, 5'd4), SEL_RD, 1'b0);
    #1 chk("lu_stall", {31'd0, stall}, 32'd1);
    step();
    chk("lu_bubble", {31'd0, ex_valid}, 32'd0);
    chk("lu_stall_clear", {31'd0, stall}, 32'd0);
    chk("lu_cnt", {16'd0, stall_cnt}, 32'd1);
    step();
    chk("lu_enter", {31'd0, ex_valid}, 32'd1);
    chk("lu_enter_dst", {27'd0, ex_dst}, 32'd4);
    exp_cnt = 1;

    // Write-back to r9 while ID reads r9
    set_id(mk(5'd1, 5'd9, 5'd5), SEL_RD, 1'b0);
    id_reg_rs = 32'h77; id_reg_rt = 32'h5; wb_we = 1'b1; wb_dst = 5'd9; wb_data = 32'hDEADBEEF;
    #1;
`ifdef ID_EX_WB_BYPASS_EN
    chk("wb_nostall", {31'd0, stall}, 32'd0);
    step();
    chk("wb_valid", {31'd0, ex_valid}, 32'd1);
    chk("wb_fwd_rt", ex_rt_val, 32'hDEADBEEF);
    chk("wb_rs", ex_rs_val, 32'h77);
`else
    chk("wb_stall", {31'd0, stall}, 32'd1);
    step();
    chk("wb_bubble", {31'd0, ex_valid}, 32'd0);
    wb_we = 1'b0; id_reg_rt = 32'hDEADBEEF;
    #1 chk("wb_reread_nostall", {31'd0, stall}, 32'd0);
    step();
    chk("wb_valid", {31'd0, ex_valid}, 32'd1);
    chk("wb_reread_rt", ex_rt_val, 32'hDEADBEEF);
    exp_cnt = 2;
`endif
    wb_we = 1'b0;

    // Register 0 is never forwarded
    set_id(mk(5'd0, 5'd3, 5'd6), SEL_RD, 1'b0);
    id_reg_rs = 32'h0; id_reg_rt = 32'h33; wb_we = 1'b1; wb_dst = 5'd0; wb_data = 32'h1234;
    #1 chk("r0_nostall", {31'd0, stall}, 32'd0);
    step();
    chk("r0_valid", {31'd0, ex_valid}, 32'd1);
    chk("r0_rs", ex_rs_val, 32'h0);
    chk("r0_rt", ex_rt_val, 32'h33);
    chk("r0_cnt", {16'd0, stall_cnt}, exp_cnt);
    wb_we = 1'b0;

    // Destination decode for RA and no-write codes
    set_id(mk(5'd1, 5'd2, 5'd3), SEL_RA, 1'b0);
    step();
    chk("ra_dst", {27'd0, ex_dst}, 32'd31);
    set_id(mk(5'd1, 5'd2, 5'd3), SEL_NONE, 1'b0);
    step();
    chk("none_dst", {27'd0, ex_dst}, 32'd0);

    // Flush wins over a load-use stall
    set_id(mk(5'd1, 5'd8, 5'd0), SEL_RT, 1'b1);
    step();
    set_id(mk(5'd8, 5'd2, 5'd7), SEL_RD, 1'b0);
    flush = 1'b1;
    #1 chk("flush_nostall", {31'd0, stall}, 32'd0);
    step();
    chk("flush_valid", {31'd0, ex_valid}, 32'd0);
    chk("flush_mrd", {31'd0, ex_mem_read}, 32'd0);
    chk("flush_sel", {30'd0, ex_gpr_w_sel}, 32'd0);
    chk("flush_cnt", {16'd0, stall_cnt}, exp_cnt);
    flush = 1'b0;

    // Asynchronous reset in the middle of a stall with stall_cnt=3
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_id(mk(5'd1, 5'd8, 5'd0), SEL_RT, 1'b1);
      step();
      set_id(mk(5'd8, 5'd2, 5'd4), SEL_RD, 1'b0);
      step();
    end
    set_id(mk(5'd1, 5'd8, 5'd0), SEL_RT, 1'b1);
    step();
    set_id(mk(5'd8, 5'd2, 5'd4), SEL_RD, 1'b0);
    #1;
    chk("pre_rst_stall", {31'd0, stall}, 32'd1);
    chk("pre_rst_cnt", {16'd0, stall_cnt}, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, ex_valid}, 32'd0);
    chk("async_rst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("async_rst_stall", {31'd0, stall}, 32'd0);
    chk("async_rst_mrd", {31'd0, ex_mem_read}, 32'd0);
    step();
    rst_n = 1'b1;

    // Randomized traffic with occasional reset pulses
    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
